// File: rtl/adder_sched_pkg.sv
// adder_sched_pkg: default sizes and round-robin index search for the shared adder scheduler
package adder_sched_pkg;

   localparam int DEF_NUM_REQ = 4;
   localparam int DEF_WIDTH   = 16;

   function automatic logic [4:0] rr_next(input logic [15:0] v, input int ptr, input int n);
      logic [3:0] k;
      rr_next = 5'd0;
      for (int i = 16; i >= 1; i--) begin
         k = 4'((ptr + i) % n);
         if (i <= n && v[k]) rr_next = {1'b1, k};
      end
   endfunction

endpackage

// File: rtl/adder_split_stage.sv
// adder_split_stage: registered W-bit adder slice with enable, {a,b,ci} -> {co,y}
module adder_split_stage #(
   parameter int W = 8
)(
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         ci,
   output logic [W-1:0] y,
   output logic         co
);

   always_ff @(posedge clk) begin
      if (reset) {co, y} <= '0;
      else if (en) {co, y} <= {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
   end

endmodule

// File: rtl/adder_rr_scheduler.sv
// adder_rr_scheduler: round-robin sharing of a two-stage split-carry adder among NUM_REQ requesters
module adder_rr_scheduler
   import adder_sched_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int WIDTH   = DEF_WIDTH,
   localparam int ID_W   = $clog2(NUM_REQ),
   localparam int HW     = WIDTH / 2
)(
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ*WIDTH-1:0] req_a,
   input  logic [NUM_REQ*WIDTH-1:0] req_b,
   input  logic [NUM_REQ-1:0]       req_ci,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [ID_W-1:0]          rsp_id,
   output logic [WIDTH-1:0]         rsp_y,
   output logic                     rsp_co,
   output logic                     idle
);

   logic              advance, fire, s1_valid, ci_sel, co_lo;
   logic [4:0]        pick;
   logic [ID_W-1:0]   ptr, s1_id;
   logic [WIDTH-1:0]  a_sel, b_sel;
   logic [HW-1:0]     s1_a_hi, s1_b_hi, y_lo, s2_y_lo, y_hi;

   assign advance   = ~rsp_valid | rsp_ready;
   assign pick      = rr_next(16'(req_valid), int'(ptr), NUM_REQ);
   assign req_ready = (advance & ~reset & pick[4]) ? NUM_REQ'(1) << pick[3:0] : '0;
   assign fire      = |(req_valid & req_ready);

   always_comb begin
      a_sel  = '0;
      b_sel  = '0;
      ci_sel = 1'b0;
      for (int i = 0; i < NUM_REQ; i++)
         if (req_ready[i]) begin
            a_sel  = req_a[i*WIDTH +: WIDTH];
            b_sel  = req_b[i*WIDTH +: WIDTH];
            ci_sel = req_ci[i];
         end
   end

   adder_split_stage #(.W(HW)) u_lo (
      .clk(clk), .reset(reset), .en(fire),
      .a(a_sel[HW-1:0]), .b(b_sel[HW-1:0]), .ci(ci_sel),
      .y(y_lo), .co(co_lo)
   );

   // Pointer only moves on a real transfer, so stalls never cost anyone their turn.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr       <= ID_W'(NUM_REQ - 1);
         s1_valid  <= 1'b0;
         s1_id     <= '0;
         s1_a_hi   <= '0;
         s1_b_hi   <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         s2_y_lo   <= '0;
      end else begin
         s1_valid <= fire | (s1_valid & ~advance);
         if (fire) begin
            ptr     <= pick[ID_W-1:0];
            s1_id   <= pick[ID_W-1:0];
            s1_a_hi <= a_sel[WIDTH-1:HW];
            s1_b_hi <= b_sel[WIDTH-1:HW];
         end
         if (advance) rsp_valid <= s1_valid;
         if (advance & s1_valid) begin
            rsp_id  <= s1_id;
            s2_y_lo <= y_lo;
         end
      end
   end

   adder_split_stage #(.W(HW)) u_hi (
      .clk(clk), .reset(reset), .en(advance & s1_valid),
      .a(s1_a_hi), .b(s1_b_hi), .ci(co_lo),
      .y(y_hi), .co(rsp_co)
   );

   assign rsp_y = {y_hi, s2_y_lo};
   assign idle  = ~s1_valid & ~rsp_valid;

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// tb_adder_rr_scheduler: directed and random scoreboard bench for adder_rr_scheduler
module tb_adder_rr_scheduler;

   localparam int N  = 4;
   localparam int W  = 16;
   localparam int IW = 2;

   logic             clk = 0, reset = 1, rsp_ready = 1;
   logic [N-1:0]     req_valid = '0, req_ci = '0, req_ready;
   logic [N*W-1:0]   req_a = '0, req_b = '0;
   logic             rsp_valid, rsp_co, idle;
   logic [IW-1:0]    rsp_id;
   logic [W-1:0]     rsp_y;
   logic [N-1:0]     fired = '0;
   logic [IW+W:0]    q[$];
   int               gnts[$];
   int               wait_cnt[N];
   int               checks = 0, errors = 0;
   logic [W-1:0]     sv_y;
   logic [IW-1:0]    sv_id;
   bit               seen;

   always #5 clk = ~clk;

   adder_rr_scheduler #(.NUM_REQ(N), .WIDTH(W)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_ci(req_ci), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_y(rsp_y), .rsp_co(rsp_co), .idle(idle)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      reset = 1;
      step();
      reset = 0;
      #1;
   endtask

   task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
      req_a[i*W +: W] = a;
      req_b[i*W +: W] = b;
      req_ci[i]       = ci;
   endtask

   task automatic op0(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                      input logic [W-1:0] ey, input logic eco);
      set_op(0, a, b, ci);
      req_valid = 4'b0001;
      #1;
      chk("op0_ready", req_ready, 4'b0001);
      step();
      req_valid = '0;
      chk("op0_s1_rsp_valid", rsp_valid, 0);
      chk("op0_s1_idle", idle, 0);
      step();
      chk("op0_rsp_valid", rsp_valid, 1);
      chk("op0_rsp_y", rsp_y, ey);
      chk("op0_rsp_co", rsp_co, eco);
      chk("op0_rsp_id", rsp_id, 0);
      step();
      chk("op0_idle_after", idle, 1);
   endtask

   // Scoreboard: pop on accepted response, push on transfer, both sampled mid-cycle.
   always @(negedge clk) begin
      fired = req_valid & req_ready;
      if (reset) begin
         q.delete();
         for (int i = 0; i < N; i++) wait_cnt[i] = 0;
      end else begin
         if (rsp_valid && rsp_ready) begin
            if (q.size() == 0) chk("unexpected_rsp", {rsp_id, rsp_co, rsp_y}, 32'hdead);
            else chk("rsp", {rsp_id, rsp_co, rsp_y}, q.pop_front());
         end
         for (int g = 0; g < N; g++)
            if (fired[g]) begin
               q.push_back({IW'(g), {1'b0, req_a[g*W +: W]} + {1'b0, req_b[g*W +: W]} + 17'(req_ci[g])});
               gnts.push_back(g);
               chk("fair_wait", wait_cnt[g] <= N, 1);
               wait_cnt[g] = 0;
               for (int i = 0; i < N; i++) if (i != g && req_valid[i]) wait_cnt[i]++;
            end
         for (int i = 0; i < N; i++) if (!req_valid[i]) wait_cnt[i] = 0;
      end
   end

   initial begin
      step();
      step();
      reset = 0;
      #1;
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_y", rsp_y, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_co", rsp_co, 0);
      chk("rst_idle", idle, 1);
      chk("rst_req_ready", req_ready, 0);

      op0(16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0);
      op0(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0);
      op0(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1);
      op0(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);

      pulse_reset();
      gnts.delete();
      for (int i = 0; i < N; i++) set_op(i, W'(16'h1111 * (i + 1)), W'(16'h0F0F + i), i[0]);
      req_valid = 4'b1111;
      for (int k = 0; k < 8; k++) begin
         step();
         if (k >= 1) chk("b2b_rsp_valid", rsp_valid, 1);
      end
      req_valid = '0;
      for (int k = 0; k < 6; k++) chk($sformatf("grant_%0d", k), gnts.size() > k ? gnts[k] : -1, k % N);
      repeat (3) step();
      chk("b2b_drained", q.size(), 0);

      pulse_reset();
      set_op(1, 16'hA5A5, 16'h5A5B, 1'b0);
      set_op(3, 16'h8000, 16'h8000, 1'b1);
      req_valid = 4'b1010;
      seen = 0;
      for (int k = 0; k < 10 && !seen; k++) begin
         step();
         seen = rsp_valid;
      end
      chk("stall_rsp_seen", seen, 1);
      rsp_ready = 0;
      #1;
      sv_y  = rsp_y;
      sv_id = rsp_id;
      chk("stall_first_id", sv_id, 1);
      chk("stall_req_ready", req_ready, 0);
      for (int k = 0; k < 3; k++) begin
         step();
         chk("stall_valid", rsp_valid, 1);
         chk("stall_y", rsp_y, sv_y);
         chk("stall_id", rsp_id, sv_id);
         chk("stall_req_ready", req_ready, 0);
         chk("stall_busy", idle, 0);
      end
      rsp_ready = 1;
      repeat (3) step();
      req_valid = '0;
      repeat (4) step();
      chk("stall_drained", q.size(), 0);

      req_valid = 4'b1111;
      step();
      step();
      reset = 1;
      #1;
      chk("rstmid_req_ready", req_ready, 0);
      step();
      chk("rstmid_rsp_valid", rsp_valid, 0);
      chk("rstmid_idle", idle, 1);
      reset = 0;
      #1;
      chk("rstmid_grant0", req_ready, 4'b0001);
      req_valid = '0;
      #1;
      repeat (4) step();
      chk("rstmid_drained", q.size(), 0);
      chk("rstmid_idle_end", idle, 1);

      for (int c = 0; c < 10000; c++) begin
         for (int i = 0; i < N; i++)
            if (!req_valid[i] || fired[i]) begin
               req_valid[i] = 1'($urandom_range(0, 1));
               set_op(i, W'($urandom), W'($urandom), 1'($urandom));
            end
         rsp_ready = $urandom_range(0, 3) != 0;
         step();
      end
      req_valid = '0;
      rsp_ready = 1;
      repeat (5) step();
      chk("rand_drained", q.size(), 0);
      chk("rand_idle", idle, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/adder_rr_scheduler.md
Name: adder_rr_scheduler

Overview:
- Shares one two-stage split-carry adder (low half in stage 1, high half in stage 2) between NUM_REQ requesters.
- Arbitrates round-robin with a valid/ready handshake on each request port and a valid/ready response port tagged with the requester ID.
- Sits between client blocks and the adder datapath; sequences the stages so one add can issue per cycle with back-pressure.

Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- WIDTH, 16, operand width; must be even; split into WIDTH/2 low and high halves
- ID_W, $clog2(NUM_REQ), localparam, width of the response tag

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester ready; at most one bit high
- req_a  in  NUM_REQ*WIDTH  packed operand A; requester i at [i*WIDTH +: WIDTH]
- req_b  in  NUM_REQ*WIDTH  packed operand B, same packing
- req_ci  in  NUM_REQ  per-requester carry-in
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  ID_W  index of the requester that issued the result
- rsp_y  out  WIDTH  sum
- rsp_co  out  1  carry-out
- idle  out  1  high when no operation is in flight and rsp_valid is low

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high.
- Reset (sampled high at an edge):
  - rsp_valid=0, rsp_id=0, rsp_y=0, rsp_co=0
  - stage-1 valid=0
  - RR pointer = NUM_REQ-1, so requester 0 has top priority
  - req_ready=0 while reset is high; idle=1 after reset
- Reset mid-operation: in-flight ops are discarded with no response. Requesters must re-present.
- advance = ~rsp_valid | rsp_ready. When advance is low, the whole pipeline holds.
- Arbitration (combinational):
  - Search starts at (ptr+1) mod NUM_REQ and selects the first requester with req_valid high.
  - req_ready[g] = advance & req_valid[g] for the selected g; all other bits are 0.
  - req_ready never depends on other ports' data.
- Handshake: a request transfers at an edge where req_valid[i] & req_ready[i].
  - On transfer, ptr <= i.
  - With no transfer, ptr holds. It also holds while stalled, so starvation-free fairness is preserved.
- Stage 1 (on transfer):
  - Registers {co_lo, y_lo} = a[WIDTH/2-1:0] + b[WIDTH/2-1:0] + ci.
  - Also registers a_hi, b_hi and id; s1_valid <= 1.
  - If advance is high and there is no transfer, s1_valid <= 0.
- Stage 2 / output: when advance is high, rsp_valid <= s1_valid. If s1_valid is set, it also registers:
  - {rsp_co, y_hi} = a_hi + b_hi + co_lo
  - rsp_y = {y_hi, y_lo}
  - rsp_id = s1 id
- Latency: a request transferred in cycle c has rsp_valid high in cycle c+2 if not stalled.
- Throughput: one op per cycle while rsp_ready stays high.
- Ordering: responses leave in issue order.
- Stall: while rsp_valid=1 & rsp_ready=0, rsp_* and stage 1 are stable and all req_ready=0.
- Simultaneous rsp accept and new issue in the same cycle is legal; there is no bubble.
- Arithmetic: modulo 2^WIDTH; the carry out of bit WIDTH-1 goes to rsp_co.
  - Example: 0xFFFF+0x0001+0 gives y=0x0000, co=1.
- The output register acts as a 1-entry buffer. No additional skid buffer is used.
- idle = ~s1_valid & ~rsp_valid.

Decomposition:
- Package adder_sched_pkg holds:
  - the default WIDTH and NUM_REQ constants
  - a function computing the round-robin next index from a valid vector and pointer
- Sub-module adder_split_stage: one WIDTH/2-bit registered adder slice with enable, {a,b,ci} -> {co,y}.
  - Instantiated twice: the low half in stage 1 and the high half in stage 2.
- The arbiter, pointer and valid/stall control stay in adder_rr_scheduler.

Test Plan:
- Reset, then req 0 alone with a=0x1234, b=0x0FCD, ci=0, rsp_ready=1.
  - Cycle c+2: rsp_valid=1, rsp_y=0x2201, rsp_co=0, rsp_id=0; idle=1 in cycle c+3.
- Carry across the half boundary: a=0x00FF, b=0x0001, ci=0 gives 0x0100, co=0. a=0xFFFF, b=0x0000, ci=1 gives 0x0000, co=1.
- All 4 requesters hold valid continuously, rsp_ready=1.
  - Grants go 0,1,2,3,0,1; responses appear back-to-back with rsp_id in the same order, one per cycle.
- Requesters 1 and 3 valid, rsp_ready low for 3 cycles after the first result.
  - rsp_* stay stable, all req_ready=0, no op lost.
  - After release, the remaining results arrive in grant order.
- Assert reset with two ops in flight.
  - Next cycle rsp_valid=0 and idle=1, no stale response afterwards, and requester 0 wins the next arbitration.
- Random valid/operand/rsp_ready for 10k cycles against a reference model.
  - Every transferred op produces exactly one response with the correct {co,y}, its ID, and in-order delivery.
  - Each continuously-valid requester waits at most NUM_REQ grants.
